// File: rtl/alu32_pkg.sv
// Shared definitions for the sequential 32-bit ALU: opcode encodings,
// controller state type and multiplier iteration count.
package alu32_pkg;

  localparam int DATA_W    = 32;
  localparam int MUL_ITERS = 32;

  localparam logic [4:0] OP_ADD = 5'b00000;
  localparam logic [4:0] OP_SUB = 5'b00001;
  localparam logic [4:0] OP_MUL = 5'b00010;
  localparam logic [4:0] OP_AND = 5'b00011;
  localparam logic [4:0] OP_OR  = 5'b00100;
  localparam logic [4:0] OP_NOR = 5'b00101;
  localparam logic [4:0] OP_XOR = 5'b00110;
  localparam logic [4:0] OP_SLL = 5'b00111;
  localparam logic [4:0] OP_SRL = 5'b01000;
  localparam logic [4:0] OP_SLT = 5'b01001;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    MUL  = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/alu32_shift_add_mul.sv
// Shift-add multiplier, one multiplier bit (LSB first) per cycle.
// Ports:
//   Clk, Reset_n   clock / async active-low reset
//   i_start        load operands (one cycle pulse)
//   i_a            multiplier (bits consumed LSB first)
//   i_b            multiplicand
//   o_done         high during the final iteration cycle
//   o_product      accumulator including the current iteration's partial
//                  product; equals the low 32 bits of a*b while o_done=1
module alu32_shift_add_mul
  import alu32_pkg::*;
#(
  parameter int WIDTH = DATA_W
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_done,
  output logic [WIDTH-1:0] o_product
);

  localparam logic [5:0] LAST_ITER = 6'(MUL_ITERS - 1);

  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0] r_mplier;
  logic [5:0]       r_cnt;
  logic             r_busy;
  logic [WIDTH-1:0] w_sum;

  assign w_sum     = r_acc + (r_mplier[0] ? r_mcand : '0);
  // Done is combinational so the controller can capture the final sum on
  // the same edge that retires the last bit.
  assign o_done    = r_busy && (r_cnt == LAST_ITER);
  assign o_product = w_sum;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
    end else if (i_start) begin
      r_acc    <= '0;
      r_mcand  <= i_b;
      r_mplier <= i_a;
      r_cnt    <= '0;
      r_busy   <= 1'b1;
    end else if (r_busy) begin
      r_acc    <= w_sum;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt + 6'd1;
      if (r_cnt == LAST_ITER) begin
        r_busy <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/alu32_seq_unit.sv
// Sequential 32-bit ALU with valid/ready request and response handshakes.
// Non-multiply ops take one EXEC cycle; multiply runs 32 shift-add cycles.
// Ports:
//   Clk, Reset_n        clock / async active-low reset
//   ReqValid/ReqReady   request handshake (ready only in IDLE)
//   ALUControl, A, B    opcode and operands, captured on accept
//   RespValid/RespReady response handshake (valid only in DONE)
//   ALUResult, Zero,    registered result flags, held until next result
//   Illegal
//   Busy                high in any state other than IDLE
//
// state | meaning
// IDLE  | waiting for a request
// EXEC  | single-cycle op decode, result loaded at end of cycle
// MUL   | shift-add multiply in progress (32 cycles)
// DONE  | result presented, waiting for RespReady
module alu32_seq_unit
  import alu32_pkg::*;
#(
  parameter int WIDTH = DATA_W
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             ReqValid,
  output logic             ReqReady,
  input  logic [4:0]       ALUControl,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             RespValid,
  input  logic             RespReady,
  output logic [WIDTH-1:0] ALUResult,
  output logic             Zero,
  output logic             Illegal,
  output logic             Busy
);

  state_t           r_state;
  logic [4:0]       r_op;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_result;
  logic             r_zero;
  logic             r_illegal;

  logic             w_accept;
  logic             w_mul_start;
  logic             w_mul_done;
  logic [WIDTH-1:0] w_mul_product;
  logic [WIDTH-1:0] w_exec_result;
  logic             w_exec_illegal;

  assign w_accept    = ReqValid && (r_state == IDLE);
  assign w_mul_start = w_accept && (ALUControl == OP_MUL);

  alu32_shift_add_mul #(.WIDTH(WIDTH)) u_mul (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .i_start   (w_mul_start),
    .i_a       (A),
    .i_b       (B),
    .o_done    (w_mul_done),
    .o_product (w_mul_product)
  );

  // Multiply never reaches EXEC, so it falls into the illegal default here.
  always_comb begin
    w_exec_result  = '0;
    w_exec_illegal = 1'b0;
    case (r_op)
      OP_ADD:  w_exec_result = r_a + r_b;
      OP_SUB:  w_exec_result = r_a - r_b;
      OP_AND:  w_exec_result = r_a & r_b;
      OP_OR:   w_exec_result = r_a | r_b;
      OP_NOR:  w_exec_result = ~(r_a | r_b);
      OP_XOR:  w_exec_result = r_a ^ r_b;
      OP_SLL:  w_exec_result = r_b << r_a[4:0];
      OP_SRL:  w_exec_result = r_b >> r_a[4:0];
      OP_SLT:  w_exec_result = {{(WIDTH-1){1'b0}}, ($signed(r_a) < $signed(r_b))};
      default: w_exec_illegal = 1'b1;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state   <= IDLE;
      r_op      <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_result  <= '0;
      r_zero    <= 1'b1;
      r_illegal <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_op    <= ALUControl;
            r_a     <= A;
            r_b     <= B;
            r_state <= (ALUControl == OP_MUL) ? MUL : EXEC;
          end
        end
        EXEC: begin
          r_result  <= w_exec_result;
          r_zero    <= (w_exec_result == '0);
          r_illegal <= w_exec_illegal;
          r_state   <= DONE;
        end
        MUL: begin
          if (w_mul_done) begin
            r_result  <= w_mul_product;
            r_zero    <= (w_mul_product == '0);
            r_illegal <= 1'b0;
            r_state   <= DONE;
          end
        end
        DONE: begin
          if (RespReady) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign ReqReady  = (r_state == IDLE);
  assign RespValid = (r_state == DONE);
  assign Busy      = (r_state != IDLE);
  assign ALUResult = r_result;
  assign Zero      = r_zero;
  assign Illegal   = r_illegal;

endmodule
